frac_scan_ctrl: RTL and testbench
=================================

FRAC_SCAN_CTRL -- requirements
Module: frac_scan_ctrl

Interface
REQ-001 Clock is clk and reset is reset; one clock domain; reset SHALL be asynchronous and active-high.
REQ-002 Parameter W, default 32, SHALL set the Qm.f coordinate width.
REQ-003 Parameter M, default 4, SHALL set the integer bits m.
REQ-004 Parameter HRES, default 640, SHALL set pixels per line.
REQ-005 Parameter VRES, default 480, SHALL set lines per frame.
REQ-006 Ports SHALL be as follows (name, direction, width, meaning):
  clk  in  1  clock
  reset  in  1  async active-high reset
  scan_start  in  1  start frame scan
  cx0, cy0  in  W  top-left coordinate, signed Qm.f
  dx, dy  in  W  pixel and line step, signed Qm.f
  max_it_in  in  16  iteration limit
  frac_ready  in  1  engine idle
  frac_done_tick  in  1  engine finished
  iter  in  16  engine iteration count
  frac_start  out  1  engine start pulse
  cx, cy  out  W  current pixel coordinate
  max_it  out  16  latched iteration limit
  wr_en  out  1  pixel write strobe
  wr_x, wr_y  out  10  pixel address
  wr_data  out  16  pixel value
  scan_busy  out  1  scan in progress
  scan_done_tick  out  1  frame complete, one cycle

Function
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT, CAP and WRITE.
REQ-008 IDLE: scan_busy=0; on scan_start it SHALL latch cx0, cy0, dx, dy and max_it_in, load cx=cx0, cy=cy0, x=0, y=0, and go to ISSUE.
REQ-009 ISSUE: frac_start SHALL equal frac_ready (combinational); when frac_ready=1 the FSM SHALL go to WAIT, otherwise it stays in ISSUE.
REQ-010 frac_start SHALL never be high for more than one cycle per pixel, and SHALL never be high outside ISSUE.
REQ-011 WAIT: on frac_done_tick the FSM SHALL go to CAP; frac_done_tick in any other state SHALL be ignored.
REQ-012 CAP: the block SHALL register iter into the data register (the engine count is final one cycle after frac_done_tick), then go to WRITE.
REQ-013 WRITE: wr_en=1 for exactly one cycle, with wr_x=x, wr_y=y and wr_data=data register.
REQ-014 Advance after WRITE, mid-line (x<HRES-1): x+1 and cx+dx, then ISSUE.
REQ-015 Advance after WRITE, end of line (x=HRES-1, y<VRES-1): x=0, cx=cx0, y+1, cy-dy, then ISSUE.
REQ-016 Advance after WRITE, last pixel (x=HRES-1, y=VRES-1): scan_done_tick=1 for that one cycle, then IDLE.
REQ-017 Coordinate arithmetic SHALL be W-bit two's complement, wrapping modulo 2^W with no saturation.
REQ-018 scan_start while scan_busy=1 SHALL be ignored; cx0, cy0, dx, dy and max_it_in changes mid-scan SHALL have no effect.
REQ-019 scan_busy SHALL be 1 in every state except IDLE.
REQ-020 cx, cy and max_it SHALL be registered outputs, held stable from ISSUE through WRITE.
REQ-021 Minimum cost per pixel SHALL be 4 cycles plus engine time.

Reset
REQ-022 Reset SHALL force IDLE, x=y=0, and all registered outputs (cx, cy, max_it, data register) to 0.
REQ-023 While reset is asserted, frac_start, wr_en, scan_done_tick and scan_busy SHALL be 0.
REQ-024 Reset mid-scan SHALL abort with no further writes; no pending engine result SHALL be written after release.

Configuration
REQ-025 With FRAC_SCAN_COLOR_EN defined, CAP SHALL store a 12-bit colour: 0 if iter==max_it, else {iter[3:0], iter[7:4], iter[11:8]}, zero-extended to 16 bits.
REQ-026 Without FRAC_SCAN_COLOR_EN, CAP SHALL store iter unchanged.

Verification (HRES=4, VRES=2, W=32, M=4, engine model unless noted)
REQ-027 Scan_start with cx0=0xE0000000, dx=0x01000000 -> 8 writes in raster order (0,0)..(3,1); the cx of the 4th pixel = 0xE3000000; the second line starts with cx=0xE0000000 and cy=cy0-dy.
REQ-028 Engine model holds frac_ready=0 for 5 cycles -> frac_start stays low, then pulses once when frac_ready rises.
REQ-029 Engine returns iter=0x0123 with FRAC_SCAN_COLOR_EN off -> wr_data=0x0123; with it on -> 0x0321; with iter==max_it=0x0100 -> 0x0000.
REQ-030 scan_start pulsed again at the 3rd pixel -> ignored; total writes=8; single scan_done_tick on the (3,1) write cycle.
REQ-031 Reset asserted in WAIT at pixel (2,0), engine tick arriving after release -> no wr_en; IDLE; scan_busy=0.
REQ-032 Real frac_engine connected, cx0=cy0=0, dx=dy=0, max_it_in=16 -> every wr_data=16.

Source files
------------

// File: rtl/frac_scan_ctrl.sv
// Raster-scan controller for an iterative fractal engine: walks an HRES x VRES
// frame in Qm.f coordinates, issues one engine job per pixel and writes the result.
// Optional build macro: FRAC_SCAN_COLOR_EN (store a 12-bit colour instead of the raw count).
module frac_scan_ctrl #(
    parameter int W    = 32,
    parameter int M    = 4,
    parameter int HRES = 640,
    parameter int VRES = 480
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         scan_start,
    input  logic [W-1:0] cx0,
    input  logic [W-1:0] cy0,
    input  logic [W-1:0] dx,
    input  logic [W-1:0] dy,
    input  logic [15:0]  max_it_in,
    input  logic         frac_ready,
    input  logic         frac_done_tick,
    input  logic [15:0]  iter,
    output logic         frac_start,
    output logic [W-1:0] cx,
    output logic [W-1:0] cy,
    output logic [15:0]  max_it,
    output logic         wr_en,
    output logic [9:0]   wr_x,
    output logic [9:0]   wr_y,
    output logic [15:0]  wr_data,
    output logic         scan_busy,
    output logic         scan_done_tick
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAP, WRITE} state_t;

    localparam logic [9:0] X_LAST = 10'(HRES - 1);
    localparam logic [9:0] Y_LAST = 10'(VRES - 1);

    // The pixel address ports are 10 bits wide and the format needs a fraction.
    if (M < 1 || M >= W || HRES < 1 || HRES > 1024 || VRES < 1 || VRES > 1024) begin : g_bad_cfg
        $error("frac_scan_ctrl: unsupported W/M/HRES/VRES combination");
    end

    state_t       state_reg, state_next;
    logic [9:0]   x_reg, y_reg;
    logic [W-1:0] cx_reg, cy_reg, cx0_reg, dx_reg, dy_reg;
    logic [15:0]  max_it_reg, data_reg, cap_value;
    logic         x_last, y_last;

    assign x_last = (x_reg == X_LAST);
    assign y_last = (y_reg == Y_LAST);

`ifdef FRAC_SCAN_COLOR_EN
    // Points that never escaped are painted black; others get a nibble-swizzled colour.
    always_comb begin
        cap_value = 16'h0000;
        if (iter != max_it_reg)
            cap_value = {4'h0, iter[3:0], iter[7:4], iter[11:8]};
    end
`else
    always_comb begin
        cap_value = iter;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (scan_start) state_next = ISSUE;
            ISSUE:   if (frac_ready) state_next = WAIT;
            WAIT:    if (frac_done_tick) state_next = CAP;
            CAP:     state_next = WRITE;
            WRITE:   state_next = (x_last && y_last) ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frac_start     = (state_reg == ISSUE) && frac_ready;
        wr_en          = (state_reg == WRITE);
        scan_done_tick = (state_reg == WRITE) && x_last && y_last;
        scan_busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            cx0_reg    <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            max_it_reg <= '0;
            data_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (scan_start) begin
                        cx0_reg    <= cx0;
                        dx_reg     <= dx;
                        dy_reg     <= dy;
                        max_it_reg <= max_it_in;
                        cx_reg     <= cx0;
                        cy_reg     <= cy0;
                        x_reg      <= '0;
                        y_reg      <= '0;
                    end
                end
                // The engine count settles one cycle after its done tick, i.e. here.
                CAP: data_reg <= cap_value;
                WRITE: begin
                    if (!x_last) begin
                        x_reg  <= x_reg + 10'd1;
                        cx_reg <= cx_reg + dx_reg;
                    end else if (!y_last) begin
                        x_reg  <= '0;
                        cx_reg <= cx0_reg;
                        y_reg  <= y_reg + 10'd1;
                        cy_reg <= cy_reg - dy_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cx      = cx_reg;
    assign cy      = cy_reg;
    assign max_it  = max_it_reg;
    assign wr_x    = x_reg;
    assign wr_y    = y_reg;
    assign wr_data = data_reg;

endmodule

// File: tb/tb_frac_scan_ctrl.sv
// Bench for frac_scan_ctrl on a 4x2 frame: an engine model answers each job, and a
// scoreboard of expected pixel writes is built from the raster/coordinate rules.
module tb_frac_scan_ctrl;

    localparam int HRES = 4;
    localparam int VRES = 2;

    logic        clk = 1'b0;
    logic        reset, scan_start;
    logic [31:0] cx0, cy0, dx, dy;
    logic [15:0] max_it_in;
    logic        frac_ready, frac_done_tick;
    logic [15:0] iter;
    logic        frac_start, wr_en, scan_busy, scan_done_tick;
    logic [31:0] cx, cy;
    logic [15:0] max_it, wr_data;
    logic [9:0]  wr_x, wr_y;

    frac_scan_ctrl #(.W(32), .M(4), .HRES(HRES), .VRES(VRES)) dut (
        .clk(clk), .reset(reset), .scan_start(scan_start),
        .cx0(cx0), .cy0(cy0), .dx(dx), .dy(dy), .max_it_in(max_it_in),
        .frac_ready(frac_ready), .frac_done_tick(frac_done_tick), .iter(iter),
        .frac_start(frac_start), .cx(cx), .cy(cy), .max_it(max_it),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .scan_busy(scan_busy), .scan_done_tick(scan_done_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] cx;
        logic [31:0] cy;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;
    int          done_cnt = 0;
    int          starts = 0;
    logic [15:0] cur_max = 0;
    logic [31:0] px_cx[64];
    logic [31:0] px_cy[64];
    logic [15:0] px_data[64];

    // engine model controls
    int          eng_mode = 0;
    logic [15:0] fixed_iter = 0;
    int          eng_delay = 2;
    int          hold_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] mandel(input logic [31:0] c_x, input logic [31:0] c_y,
                                           input logic [15:0] mx);
        real cr, ci, zr, zi, t;
        int  n;
        cr = $itor($signed(c_x)) / 268435456.0;
        ci = $itor($signed(c_y)) / 268435456.0;
        zr = 0.0; zi = 0.0; n = 0;
        while (n < int'(mx) && (zr * zr + zi * zi) <= 4.0) begin
            t  = zr * zr - zi * zi + cr;
            zi = 2.0 * zr * zi + ci;
            zr = t;
            n++;
        end
        return 16'(n);
    endfunction

    function automatic logic [15:0] eng_result(input logic [31:0] c_x, input logic [31:0] c_y,
                                               input logic [15:0] mx);
        case (eng_mode)
            1:       return fixed_iter;
            2:       return mandel(c_x, c_y, mx);
            default: return {c_y[31:24], c_x[31:24]};
        endcase
    endfunction

    function automatic logic [15:0] model_px(input logic [15:0] it, input logic [15:0] mx);
`ifdef FRAC_SCAN_COLOR_EN
        if (it == mx) return 16'h0000;
        return {4'h0, it[3:0], it[7:4], it[11:8]};
`else
        return it;
`endif
    endfunction

    // Engine: accepts a job when frac_start is seen, ticks done after eng_delay cycles
    // with a bogus count, and only presents the real count on the following cycle.
    initial begin : engine
        logic        st;
        logic [31:0] scx, scy;
        logic [15:0] smx, res;
        int          cnt;
        logic        pend;
        frac_ready = 1'b1; frac_done_tick = 1'b0; iter = 16'h0;
        cnt = 0; pend = 1'b0; res = 16'h0;
        forever begin
            @(negedge clk);
            st = frac_start; scx = cx; scy = cy; smx = max_it;
            @(posedge clk);
            #1;
            frac_done_tick = 1'b0;
            if (pend) begin
                iter = res;
                pend = 1'b0;
            end
            if (st) begin
                frac_ready = 1'b0;
                cnt = eng_delay;
                res = eng_result(scx, scy, smx);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    frac_done_tick = 1'b1;
                    iter = ~res;
                    pend = 1'b1;
                end
            end else if (hold_cnt > 0) begin
                frac_ready = 1'b0;
                hold_cnt--;
            end else begin
                frac_ready = 1'b1;
            end
        end
    end

    // Compare process: checks every start, every write and the reset-time outputs.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                starts = 0;
                chk("rst_frac_start", frac_start, 0);
                chk("rst_wr_en", wr_en, 0);
                chk("rst_done_tick", scan_done_tick, 0);
                chk("rst_busy", scan_busy, 0);
                chk("rst_cx", cx, 0);
                chk("rst_cy", cy, 0);
                chk("rst_max_it", max_it, 0);
            end else begin
                if (frac_start) begin
                    chk("start_needs_ready", frac_ready, 1);
                    chk("start_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        chk("start_cx", cx, sb[0].cx);
                        chk("start_cy", cy, sb[0].cy);
                        chk("start_max_it", max_it, cur_max);
                    end
                    starts++;
                end
                if (wr_en) begin
                    chk("write_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("wr_x", wr_x, e.x);
                        chk("wr_y", wr_y, e.y);
                        chk("wr_data", wr_data, e.data);
                        chk("wr_cx_held", cx, e.cx);
                        chk("wr_cy_held", cy, e.cy);
                        chk("starts_per_pixel", starts, 1);
                        chk("done_tick_on_write", scan_done_tick, sb.size() == 0);
                    end
                    $display("WR #%0d (%0d,%0d) cx=%h cy=%h data=%h done=%0d",
                             wr_count, wr_x, wr_y, cx, cy, wr_data, scan_done_tick);
                    px_cx[wr_count & 63]   = cx;
                    px_cy[wr_count & 63]   = cy;
                    px_data[wr_count & 63] = wr_data;
                    wr_count++;
                    starts = 0;
                end else if (scan_done_tick) begin
                    chk("done_without_write", scan_done_tick, 0);
                end
                if (scan_done_tick) done_cnt++;
            end
        end
    end

    task automatic start_scan(input logic [31:0] c0x, input logic [31:0] c0y,
                              input logic [31:0] ddx, input logic [31:0] ddy,
                              input logic [15:0] mx, input int hold);
        exp_t p;
        @(posedge clk);
        #1;
        cx0 = c0x; cy0 = c0y; dx = ddx; dy = ddy; max_it_in = mx;
        cur_max = mx;
        hold_cnt = hold;
        for (int y = 0; y < VRES; y++) begin
            for (int x = 0; x < HRES; x++) begin
                p.x    = 10'(x);
                p.y    = 10'(y);
                p.cx   = c0x + 32'(x) * ddx;
                p.cy   = c0y - 32'(y) * ddy;
                p.data = model_px(eng_result(p.cx, p.cy, mx), mx);
                sb.push_back(p);
            end
        end
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        cx0 = ~c0x; cy0 = ~c0y; dx = ~ddx; dy = ~ddy; max_it_in = ~mx;
    endtask

    task automatic wait_scan(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scan_completed_in_time", done_cnt != d0, 1);
        @(negedge clk);
        chk("busy_after_done", scan_busy, 0);
        chk("all_pixels_written", sb.size(), 0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("write_progress_in_time", wr_count >= target, 1);
    endtask

    initial begin : main
        int d0, w0, n;
        reset = 1'b1; scan_start = 1'b0;
        cx0 = 0; cy0 = 0; dx = 0; dy = 0; max_it_in = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_busy_after_reset", scan_busy, 0);
        chk("idle_cx_after_reset", cx, 0);

        // raster order, coordinate stepping, slow engine ready, ignored restart
        eng_mode = 0; eng_delay = 2; wr_count = 0; d0 = done_cnt;
        start_scan(32'hE000_0000, 32'h1000_0000, 32'h0100_0000, 32'h0080_0000, 16'h0100, 5);
        wait_writes(2, 200);
        @(posedge clk); #1;
        cx0 = 32'h0; dx = 32'h0; max_it_in = 16'h0; scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        wait_scan(500);
        chk("lit_px3_cx", px_cx[3], 32'hE300_0000);
        chk("lit_px4_cx", px_cx[4], 32'hE000_0000);
        chk("lit_px4_cy", px_cy[4], 32'h0F80_0000);
        chk("lit_write_count", wr_count, 8);
        chk("lit_done_count", done_cnt - d0, 1);

        // stored value: raw count or colour
        eng_mode = 1; fixed_iter = 16'h0123; eng_delay = 1; wr_count = 0;
        start_scan(32'h0, 32'h0, 32'h0010_0000, 32'h0010_0000, 16'h0200, 0);
        wait_scan(500);
`ifdef FRAC_SCAN_COLOR_EN
        chk("lit_data_0123", px_data[0], 16'h0321);
`else
        chk("lit_data_0123", px_data[0], 16'h0123);
`endif
        fixed_iter = 16'h0100; wr_count = 0;
        start_scan(32'h0, 32'h0, 32'h0010_0000, 32'h0010_0000, 16'h0100, 0);
        wait_scan(500);
`ifdef FRAC_SCAN_COLOR_EN
        chk("lit_data_at_max", px_data[7], 16'h0000);
`else
        chk("lit_data_at_max", px_data[7], 16'h0100);
`endif

        // reset while waiting on pixel (2,0); the engine tick lands after release
        eng_mode = 0; eng_delay = 8; wr_count = 0;
        start_scan(32'h1000_0000, 32'h2000_0000, 32'h0200_0000, 32'h0100_0000, 16'h0040, 0);
        wait_writes(2, 200);
        n = 0;
        while (!frac_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("third_pixel_issued", frac_start, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        w0 = wr_count;
        repeat (20) @(negedge clk);
        chk("no_write_after_abort", wr_count - w0, 0);
        chk("idle_after_abort", scan_busy, 0);
        chk("writes_before_abort", w0, 2);

        // two's complement wrap of both coordinates
        eng_delay = 1; wr_count = 0;
        start_scan(32'h7F00_0000, 32'h8000_0000, 32'h0100_0000, 32'h0000_0001, 16'h0010, 0);
        wait_scan(500);
        chk("lit_cx_wrap", px_cx[1], 32'h8000_0000);
        chk("lit_cy_wrap", px_cy[4], 32'h7FFF_FFFF);

        // reference iteration at c=0 never escapes
        eng_mode = 2; eng_delay = 3; wr_count = 0;
        start_scan(32'h0, 32'h0, 32'h0, 32'h0, 16'd16, 0);
        wait_scan(500);
        for (int i = 0; i < 8; i++) begin
`ifdef FRAC_SCAN_COLOR_EN
            chk("lit_mandel_c0", px_data[i], 16'h0000);
`else
            chk("lit_mandel_c0", px_data[i], 16'd16);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
